// File: rtl/lfsr_display_gen.sv
// rtl/lfsr_display_gen.sv - XNOR Fibonacci LFSR feeding a display shift register, run/hold/step/load modes
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (advance out of the all-ones lockup state loads zero).
module lfsr_display_gen #(
  parameter int                LFSR_W  = 4,
  parameter logic [LFSR_W-1:0] TAPS    = 4'b0011,
  parameter int                DISP_W  = 8,
  parameter int                TAP_BIT = 2,
  parameter int                DIV     = 100000000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic [DISP_W-1:0] disp_q,
  output logic              tick,
  output logic              lockup
);

  localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_LOAD = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              step_prev_q, step_prev_d;
  logic [LFSR_W-1:0] lfsr_d, lfsr_shift;
  logic [DISP_W-1:0] disp_d, disp_shift;
  logic              tick_d;
  logic              fb;
  logic              advance;

  // All-ones is the fixed point of XNOR feedback.
  assign lockup = &lfsr_q;

  // Display shifts in the tapped LFSR bit at its MSB; a one-deep display just takes the bit.
  if (DISP_W == 1) begin : g_disp_one
    assign disp_shift = lfsr_q[TAP_BIT];
  end else begin : g_disp_many
    assign disp_shift = {lfsr_q[TAP_BIT], disp_q[DISP_W-1:1]};
  end

  // Next-state logic: mode decode, prescaler, advance condition and register updates.
  always_comb begin
    state_d     = en ? state_t'(mode) : S_HOLD;
    step_prev_d = step;

    fb         = ~^(lfsr_q & TAPS);
    lfsr_shift = {fb, lfsr_q[LFSR_W-1:1]};
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (lockup) begin
      lfsr_shift = '0;
    end
`else
`endif

    case (state_q)
      S_RUN:   advance = (pre_q == PRE_MAX);
      S_STEP:  advance = step && !step_prev_q;
      default: advance = 1'b0;
    endcase

    case (state_q)
      S_HOLD:  pre_d = pre_q;
      S_RUN:   pre_d = advance ? '0 : pre_q + 1'b1;
      default: pre_d = '0;
    endcase

    lfsr_d = lfsr_q;
    disp_d = disp_q;
    if (state_q == S_LOAD) begin
      lfsr_d = seed_in;
      disp_d = '0;
    end else if (advance) begin
      lfsr_d = lfsr_shift;
      disp_d = disp_shift;
    end

    tick_d = advance;
  end

  // State, prescaler, step edge history and output registers; clr clears everything at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_HOLD;
      pre_q       <= '0;
      step_prev_q <= 1'b0;
      lfsr_q      <= '0;
      disp_q      <= '0;
      tick        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      step_prev_q <= step_prev_d;
      lfsr_q      <= lfsr_d;
      disp_q      <= disp_d;
      tick        <= tick_d;
    end
  end

endmodule

// File: tb/tb_lfsr_display_gen.sv
// tb/tb_lfsr_display_gen.sv - self-checking bench for lfsr_display_gen with DIV=4
module tb_lfsr_display_gen;

  localparam int         DIVV   = 4;
  localparam logic [3:0] TAPS_M = 4'b0011;
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       step = 1'b0;
  logic [3:0] seed_in = 4'b0000;
  logic [3:0] lfsr_q;
  logic [7:0] disp_q;
  logic       tick;
  logic       lockup;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers
  int m_lfsr = 0;
  int m_disp = 0;
  int m_presc = 0;
  int m_mode = 0;
  int m_stepd = 0;
  int m_tick = 0;

  lfsr_display_gen #(
    .LFSR_W (4),
    .TAPS   (TAPS_M),
    .DISP_W (8),
    .TAP_BIT(2),
    .DIV    (DIVV)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .mode   (mode),
    .step   (step),
    .seed_in(seed_in),
    .lfsr_q (lfsr_q),
    .disp_q (disp_q),
    .tick   (tick),
    .lockup (lockup)
  );

  always #5 clk = ~clk;

  function automatic int next_lfsr(int v);
    int fb;
    if (RECOVER && v == 15) return 0;
    fb = ($countones(v & int'(TAPS_M)) % 2 == 0) ? 1 : 0;
    return (v >> 1) | (fb << 3);
  endfunction

  function automatic int next_disp(int d, int l);
    return (d >> 1) | (((l >> 2) & 1) << 7);
  endfunction

  function automatic bit adv_now();
    return (m_mode == 1 && m_presc == DIVV - 1) ||
           (m_mode == 2 && step === 1'b1 && m_stepd == 0);
  endfunction

  // Behavioural model: effective mode lags inputs by one edge, advance follows the mode rules
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_lfsr <= 0; m_disp <= 0; m_presc <= 0; m_mode <= 0; m_stepd <= 0; m_tick <= 0;
    end else begin
      m_mode  <= en ? int'(mode) : 0;
      m_stepd <= (step === 1'b1) ? 1 : 0;
      m_tick  <= adv_now() ? 1 : 0;
      if (m_mode == 3) begin
        m_lfsr <= int'(seed_in); m_disp <= 0; m_presc <= 0;
      end else begin
        if (m_mode == 1) m_presc <= (m_presc + 1) % DIVV;
        else if (m_mode == 2) m_presc <= 0;
        if (adv_now()) begin
          m_lfsr <= next_lfsr(m_lfsr);
          m_disp <= next_disp(m_disp, m_lfsr);
        end
      end
    end
  end

  task automatic do_reset();
    en = 1'b0; mode = 2'b00; step = 1'b0; seed_in = 4'b0000;
    clr = 1'b0;
    #1 clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (lfsr_q !== 4'b0000) begin errors++; $display("FAIL reset_lfsr: got %b expected 0000", lfsr_q); end
    checks++; if (disp_q !== 8'h00) begin errors++; $display("FAIL reset_disp: got %h expected 00", disp_q); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b expected 0", lockup); end
  endtask

  task automatic test_run_sequence();
    logic [3:0] exp_seq [6] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b0111, 4'b1011};
    int gap;
    bit got;
    do_reset();
    checks++; if (lfsr_q !== exp_seq[0]) begin errors++; $display("FAIL run_seq0: got %b expected %b", lfsr_q, exp_seq[0]); end
    en = 1'b1; mode = 2'b01;
    for (int k = 1; k < 6; k++) begin
      gap = 0; got = 1'b0;
      while (!got && gap < 12) begin
        @(negedge clk); gap++;
        if (tick === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL run_tick_timeout: advance %0d not seen within %0d cycles", k, gap); end
      else begin
        if (lfsr_q !== exp_seq[k]) begin errors++; $display("FAIL run_seq%0d: got %b expected %b", k, lfsr_q, exp_seq[k]); end
        checks++;
        if (gap !== ((k == 1) ? 5 : 4)) begin errors++; $display("FAIL run_gap%0d: got %0d expected %0d", k, gap, (k == 1) ? 5 : 4); end
      end
    end
  endtask

  task automatic test_period();
    bit seen [16];
    int advances, distinct, cyc;
    logic [3:0] prev;
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    advances = 0; distinct = 0; cyc = 0;
    prev = lfsr_q;
    en = 1'b1; mode = 2'b01;
    while (advances < 15 && cyc < 100) begin
      @(negedge clk); cyc++;
      checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL period_lockup: got %b expected 0 at lfsr %b", lockup, lfsr_q); end
      if (tick === 1'b1) begin
        advances++;
        checks++; if (disp_q[7] !== prev[2]) begin errors++; $display("FAIL period_disp_msb: got %b expected %b", disp_q[7], prev[2]); end
        if (!seen[lfsr_q]) begin seen[lfsr_q] = 1'b1; distinct++; end
      end
      prev = lfsr_q;
    end
    checks++; if (advances != 15) begin errors++; $display("FAIL period_advances: got %0d expected 15", advances); end
    checks++; if (lfsr_q !== 4'b0000) begin errors++; $display("FAIL period_wrap: got %b expected 0000", lfsr_q); end
    checks++; if (distinct != 15) begin errors++; $display("FAIL period_distinct: got %0d expected 15", distinct); end
  endtask

  task automatic test_step_hold();
    int ticks;
    do_reset();
    en = 1'b1; mode = 2'b10; step = 1'b0;
    repeat (3) @(negedge clk);
    ticks = 0;
    step = 1'b1;
    repeat (10) begin @(negedge clk); if (tick === 1'b1) ticks++; end
    step = 1'b0;
    repeat (2) begin @(negedge clk); if (tick === 1'b1) ticks++; end
    checks++; if (ticks != 1) begin errors++; $display("FAIL step_ticks: got %0d expected 1", ticks); end
    checks++; if (lfsr_q !== 4'b1000) begin errors++; $display("FAIL step_lfsr: got %b expected 1000", lfsr_q); end
    checks++; if (disp_q !== 8'h00) begin errors++; $display("FAIL step_disp: got %h expected 00", disp_q); end
  endtask

  task automatic test_lockup();
    logic [3:0] exp_l;
    logic       exp_k;
    do_reset();
    en = 1'b1; mode = 2'b11; seed_in = 4'b1111;
    repeat (3) @(negedge clk);
    checks++; if (lfsr_q !== 4'b1111) begin errors++; $display("FAIL lock_seed: got %b expected 1111", lfsr_q); end
    checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL lock_flag_set: got %b expected 1", lockup); end
    mode = 2'b10; step = 1'b0;
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL lock_tick: got %b expected 1", tick); end
    step = 1'b0;
    @(negedge clk);
    exp_l = RECOVER ? 4'b0000 : 4'b1111;
    exp_k = RECOVER ? 1'b0 : 1'b1;
    checks++; if (lfsr_q !== exp_l) begin errors++; $display("FAIL lock_after_step: got %b expected %b", lfsr_q, exp_l); end
    checks++; if (lockup !== exp_k) begin errors++; $display("FAIL lock_flag_after: got %b expected %b", lockup, exp_k); end
    checks++; if (disp_q !== 8'h80) begin errors++; $display("FAIL lock_disp: got %h expected 80", disp_q); end
  endtask

  task automatic wait_ticks(input int n, input string name);
    int cyc, seen;
    cyc = 0; seen = 0;
    while (seen < n && cyc < 40) begin
      @(negedge clk); cyc++;
      if (tick === 1'b1) seen++;
    end
    checks++;
    if (seen != n) begin errors++; $display("FAIL %s_timeout: got %0d ticks expected %0d", name, seen, n); end
  endtask

  task automatic test_en_freeze();
    int cyc;
    bit got;
    do_reset();
    en = 1'b1; mode = 2'b01;
    wait_ticks(2, "freeze");
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (lfsr_q !== 4'b1100 || disp_q !== 8'h00 || tick !== 1'b0) begin
        errors++; $display("FAIL freeze_hold: got lfsr %b disp %h tick %b expected 1100 00 0", lfsr_q, disp_q, tick);
      end
    end
    en = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk); cyc++;
      if (tick === 1'b1) got = 1'b1;
    end
    checks++; if (!got || cyc != 2) begin errors++; $display("FAIL freeze_resume_gap: got %0d cycles expected 2", cyc); end
    checks++; if (lfsr_q !== 4'b1110) begin errors++; $display("FAIL freeze_resume_lfsr: got %b expected 1110", lfsr_q); end
  endtask

  task automatic test_clr_async();
    do_reset();
    en = 1'b1; mode = 2'b01;
    wait_ticks(3, "clr");
    checks++;
    if (lfsr_q !== 4'b1110 || disp_q !== 8'h80 || tick !== 1'b1) begin
      errors++; $display("FAIL clr_pre: got lfsr %b disp %h tick %b expected 1110 80 1", lfsr_q, disp_q, tick);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if (lfsr_q !== 4'b0000 || disp_q !== 8'h00 || tick !== 1'b0) begin
      errors++; $display("FAIL clr_async: got lfsr %b disp %h tick %b expected 0000 00 0", lfsr_q, disp_q, tick);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== 1'b0 || lfsr_q !== 4'b0000) begin
        errors++; $display("FAIL clr_restart_idle%0d: got tick %b lfsr %b expected 0 0000", i, tick, lfsr_q);
      end
    end
    @(negedge clk);
    checks++;
    if (tick !== 1'b1 || lfsr_q !== 4'b1000) begin
      errors++; $display("FAIL clr_restart_adv: got tick %b lfsr %b expected 1 1000", tick, lfsr_q);
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; mode = 2'b01;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++; if (lfsr_q !== 4'(m_lfsr)) begin errors++; $display("FAIL rand_lfsr cyc %0d: got %b expected %b", i, lfsr_q, 4'(m_lfsr)); end
      checks++; if (disp_q !== 8'(m_disp)) begin errors++; $display("FAIL rand_disp cyc %0d: got %h expected %h", i, disp_q, 8'(m_disp)); end
      checks++; if (tick !== 1'(m_tick)) begin errors++; $display("FAIL rand_tick cyc %0d: got %b expected %b", i, tick, 1'(m_tick)); end
      checks++; if (lockup !== (m_lfsr == 15)) begin errors++; $display("FAIL rand_lockup cyc %0d: got %b expected %b", i, lockup, m_lfsr == 15); end
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      step = ($urandom_range(0, 2) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    test_reset();
    test_run_sequence();
    test_period();
    test_step_hold();
    test_lockup();
    test_en_freeze();
    test_clr_async();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
